// File: rtl/tia_player_graphics_scan.sv
// Player graphics serializer: turns the position counter's start/count strobes
// into a per-pixel graphics bit, with 1x/2x/4x stretch, reflection and VDEL select.
module tia_player_graphics_scan #(
    parameter int GFX_WIDTH = 8,
    localparam int IDX_W = $clog2(GFX_WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_bar,
    input  logic                 fstob,
    input  logic                 count_bar,
    input  logic [2:0]           nusiz,
    input  logic [GFX_WIDTH-1:0] grp_new,
    input  logic [GFX_WIDTH-1:0] grp_old,
    input  logic                 vdel,
    input  logic                 refp,
    output logic                 pixel,
    output logic                 scan_active,
    output logic [IDX_W-1:0]     bit_index
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SCAN  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GFX_WIDTH - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     bit_index_q, bit_index_d;
    logic [1:0]           stretch_q, stretch_d;
    logic [1:0]           scale_m1;
    logic [GFX_WIDTH-1:0] gfx;
    logic [IDX_W-1:0]     sel;

    always_comb begin
        // Stretch limit is re-evaluated every clock, so a size change lands at the next edge.
        scale_m1 = 2'd0;
        if (nusiz == 3'b101) begin
            scale_m1 = 2'd1;
        end else if (nusiz == 3'b111) begin
            scale_m1 = 2'd3;
        end

        state_d     = state_q;
        bit_index_d = bit_index_q;
        stretch_d   = stretch_q;

        case (state_q)
            ST_IDLE: begin
                bit_index_d = '0;
                stretch_d   = '0;
                if (!start_bar) begin
                    state_d = fstob ? ST_DELAY : ST_SCAN;
                end
            end
            ST_DELAY: begin
                state_d     = ST_SCAN;
                bit_index_d = '0;
                stretch_d   = '0;
            end
            ST_SCAN: begin
                if (!start_bar) begin
                    state_d     = fstob ? ST_DELAY : ST_SCAN;
                    bit_index_d = '0;
                    stretch_d   = '0;
                end else if (!count_bar) begin
                    // >= rather than == so shrinking below the current stretch ends the bit cleanly.
                    if (stretch_q >= scale_m1) begin
                        stretch_d = '0;
                        if (bit_index_q == LAST_IDX) begin
                            state_d     = ST_IDLE;
                            bit_index_d = '0;
                        end else begin
                            bit_index_d = bit_index_q + 1'b1;
                        end
                    end else begin
                        stretch_d = stretch_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                bit_index_d = '0;
                stretch_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_index_q <= '0;
            stretch_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_index_q <= bit_index_d;
            stretch_q   <= stretch_d;
        end
    end

    // Graphics select is combinational so register writes show up in the same pixel slot.
    always_comb begin
        gfx         = vdel ? grp_old : grp_new;
        sel         = refp ? bit_index_q : (LAST_IDX - bit_index_q);
        scan_active = (state_q == ST_SCAN);
        bit_index   = bit_index_q;
        pixel       = scan_active & gfx[sel];
    end

endmodule

// File: tb/tb_tia_player_graphics_scan.sv
// Directed bench for tia_player_graphics_scan: hand-computed pixel sequences
// pushed into an expected queue and compared one pixel slot at a time.
module tb_tia_player_graphics_scan;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_bar;
    logic       fstob;
    logic       count_bar;
    logic [2:0] nusiz;
    logic [7:0] grp_new;
    logic [7:0] grp_old;
    logic       vdel;
    logic       refp;
    logic       pixel;
    logic       scan_active;
    logic [2:0] bit_index;

    int tests_run = 0;
    int tests_failed = 0;
    logic exp_q[$];

    tia_player_graphics_scan #(.GFX_WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_bar   (start_bar),
        .fstob       (fstob),
        .count_bar   (count_bar),
        .nusiz       (nusiz),
        .grp_new     (grp_new),
        .grp_old     (grp_old),
        .vdel        (vdel),
        .refp        (refp),
        .pixel       (pixel),
        .scan_active (scan_active),
        .bit_index   (bit_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single start pulse; outputs are sampled in the slot that follows the edge.
    task automatic start_copy(input logic f);
        start_bar = 1'b0;
        fstob     = f;
        tick();
        start_bar = 1'b1;
        fstob     = 1'b0;
    endtask

    // Expected pixels, first slot in the MSB of pat[n-1:0].
    task automatic run_expect(input string tag, input logic [31:0] pat, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(pat[n-1-i]);
        while (exp_q.size() > 0) begin
            check({tag, "_pix"}, {31'd0, pixel}, {31'd0, exp_q.pop_front()});
            check({tag, "_act"}, {31'd0, scan_active}, 32'd1);
            tick();
        end
        check({tag, "_end"}, {31'd0, scan_active}, 32'd0);
    endtask

    initial begin
        logic [7:0] g;
        int         exp_idx;
        reset = 1'b1; start_bar = 1'b1; fstob = 1'b0; count_bar = 1'b0;
        nusiz = 3'b000; grp_new = 8'b1011_0001; grp_old = 8'h00; vdel = 1'b0; refp = 1'b0;
        tick(); tick();
        check("rst_pix", {31'd0, pixel}, 32'd0);
        check("rst_act", {31'd0, scan_active}, 32'd0);
        check("rst_idx", {29'd0, bit_index}, 32'd0);
        reset = 1'b0;
        tick();
        check("idle_act", {31'd0, scan_active}, 32'd0);

        // Basic 1x, MSB first
        start_copy(1'b0);
        run_expect("x1", 32'b1011_0001, 8);
        check("x1_idx0", {29'd0, bit_index}, 32'd0);

        // 2x reflected
        grp_new = 8'hC1; refp = 1'b1; nusiz = 3'b101;
        start_copy(1'b0);
        run_expect("x2r", 32'b1100_0000_0000_1111, 16);

        // 4x reflected
        nusiz = 3'b111;
        start_copy(1'b0);
        run_expect("x4r", 32'hF000_00FF, 32);

        // Delayed start: nothing visible in the DELAY slot
        grp_new = 8'b1011_0001; refp = 1'b0; nusiz = 3'b000;
        start_copy(1'b1);
        check("dly_act", {31'd0, scan_active}, 32'd0);
        check("dly_pix", {31'd0, pixel}, 32'd0);
        check("dly_idx", {29'd0, bit_index}, 32'd0);
        tick();
        run_expect("dly", 32'b1011_0001, 8);

        // Hold for 5 slots at bit 3
        g = 8'b1011_0001;
        start_copy(1'b0);
        for (int c = 0; c < 13; c++) begin
            exp_idx = (c <= 3) ? c : ((c <= 8) ? 3 : c - 5);
            check("hold_idx", {29'd0, bit_index}, exp_idx);
            check("hold_pix", {31'd0, pixel}, {31'd0, g[7-exp_idx]});
            count_bar = (c >= 3 && c < 8) ? 1'b1 : 1'b0;
            tick();
        end
        check("hold_end", {31'd0, scan_active}, 32'd0);

        // Restart at bit 5
        start_copy(1'b0);
        repeat (5) tick();
        check("rs_idx5", {29'd0, bit_index}, 32'd5);
        start_copy(1'b0);
        check("rs_idx0", {29'd0, bit_index}, 32'd0);
        run_expect("rs", 32'b1011_0001, 8);

        // VDEL toggle mid-scan changes pixel in the same slot
        grp_old = 8'hFF; grp_new = 8'h00;
        start_copy(1'b0);
        tick(); tick();
        check("vd_pix0", {31'd0, pixel}, 32'd0);
        vdel = 1'b1;
        #1;
        check("vd_pix1", {31'd0, pixel}, 32'd1);
        repeat (6) tick();
        check("vd_end", {31'd0, scan_active}, 32'd0);
        vdel = 1'b0;

        // Shrink 4x -> 1x while stretch = 2
        grp_new = 8'b1011_0001; nusiz = 3'b111;
        start_copy(1'b0);
        for (int c = 0; c < 3; c++) begin
            check("shr_hold", {29'd0, bit_index}, 32'd0);
            tick();
            if (c == 1) nusiz = 3'b000;
        end
        for (int b = 1; b < 8; b++) begin
            check("shr_idx", {29'd0, bit_index}, b);
            check("shr_pix", {31'd0, pixel}, {31'd0, g[7-b]});
            tick();
        end
        check("shr_end", {31'd0, scan_active}, 32'd0);

        // Reset mid-scan aborts; a later start scans normally
        start_copy(1'b0);
        repeat (3) tick();
        check("mr_idx3", {29'd0, bit_index}, 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_pix", {31'd0, pixel}, 32'd0);
        check("mr_act", {31'd0, scan_active}, 32'd0);
        check("mr_idx", {29'd0, bit_index}, 32'd0);
        start_copy(1'b0);
        run_expect("mr_rerun", 32'b1011_0001, 8);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
